// File: rtl/adler32_pkg.sv
// adler32_pkg: shared constants, feeder FSM states and byte-lane helper for the Adler-32 engine.
package adler32_pkg;
    localparam int ADLER_MOD = 65521;
    localparam int BYTE_W    = 8;
    localparam int WORD_W    = 32;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} feeder_state_t;

    // idx counts bytes in emission order; MSB-first emission maps idx 0 to lane 3
    function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] w, input logic [1:0] idx,
                                                    input logic lsb_first);
        logic [1:0] s;
        s = lsb_first ? idx : ~idx;
        return w[{s, 3'b000} +: BYTE_W];
    endfunction
endpackage

// File: rtl/sync_word_fifo.sv
// sync_word_fifo: show-ahead synchronous FIFO; push into full and pop from empty are ignored.
module sync_word_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push, w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign full   = r_count == CW'(DEPTH);
    assign empty  = r_count == '0;
    assign count  = r_count;
    assign rdata  = r_mem[r_rptr];

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr] <= wdata;
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/adler32_byte_feeder.sv
// adler32_byte_feeder: buffers 32-bit message words and serializes them one byte per clock
// into the checksum engine, forcing an idle gap after each message.
module adler32_byte_feeder
    import adler32_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int BYTE_ORDER = 0,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    input  logic [1:0]        in_nbytes,
    output logic              data_valid,
    output logic [BYTE_W-1:0] data,
    output logic              last_data,
    output logic [15:0]       byte_count,
    output logic              busy
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = WORD_W + 3;

    logic              w_push, w_pop, w_full, w_empty, w_final, w_to_idle;
    logic [CW-1:0]     w_count, w_count_next;
    logic [FW-1:0]     w_rdata;
    logic [1:0]        w_last_idx;

    feeder_state_t     r_state;
    logic [WORD_W-1:0] r_word;
    logic              r_last, r_first;
    logic [1:0]        r_nb, r_idx;
    logic [3:0]        r_gap;
    logic              r_in_ready, r_data_valid, r_last_data, r_busy;
    logic [BYTE_W-1:0] r_data;
    logic [15:0]       r_byte_count;

    sync_word_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({in_data, in_last, in_nbytes}),
        .rdata (w_rdata),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_push       = in_valid && r_in_ready && !w_full;
    assign w_last_idx   = (r_last && r_nb != 2'd0) ? r_nb - 2'd1 : 2'd3;
    assign w_final      = r_idx == w_last_idx;
    // Pops happen from IDLE, at the seam between words, and on the final gap cycle so gaps are exact
    assign w_pop        = !w_empty && (r_state == IDLE || (r_state == SHIFT && w_final && !r_last) ||
                                       (r_state == GAP && r_gap == 4'd1));
    assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);
    assign w_to_idle    = !w_pop && ((r_state == IDLE) || (r_state == GAP && r_gap == 4'd1) ||
                                     (r_state == SHIFT && w_final && (!r_last || GAP_CYCLES == 0)));

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_word       <= '0;
            r_last       <= 1'b0;
            r_nb         <= '0;
            r_idx        <= '0;
            r_gap        <= '0;
            r_first      <= 1'b1;
            r_in_ready   <= 1'b0;
            r_data_valid <= 1'b0;
            r_data       <= '0;
            r_last_data  <= 1'b0;
            r_byte_count <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_in_ready  <= w_count_next != CW'(DEPTH);
            r_busy      <= !w_to_idle || w_count_next != '0;
            r_last_data <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_data_valid <= 1'b0;
                    if (w_pop) r_state <= SHIFT;
                end
                SHIFT: begin
                    r_data_valid <= 1'b1;
                    r_data       <= pick_byte(r_word, r_idx, BYTE_ORDER != 0);
                    r_byte_count <= r_first ? 16'd1 : (&r_byte_count ? r_byte_count : r_byte_count + 16'd1);
                    r_first      <= 1'b0;
                    r_idx        <= r_idx + 2'd1;
                    if (w_final && r_last) begin
                        r_last_data <= 1'b1;
                        r_first     <= 1'b1;
                        r_gap       <= 4'(GAP_CYCLES);
                        r_state     <= (GAP_CYCLES > 0) ? GAP : IDLE;
                    end else if (w_final && !w_pop) begin
                        r_state <= IDLE;
                    end
                end
                GAP: begin
                    r_data_valid <= 1'b0;
                    r_gap        <= r_gap - 4'd1;
                    if (r_gap == 4'd1) r_state <= w_pop ? SHIFT : IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (w_pop) begin
                {r_word, r_last, r_nb} <= w_rdata;
                r_idx                  <= 2'd0;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign data_valid = r_data_valid;
    assign data       = r_data;
    assign last_data  = r_last_data;
    assign byte_count = r_byte_count;
    assign busy       = r_busy;
endmodule

// File: tb/tb_adler32_byte_feeder.sv
// tb_adler32_byte_feeder: directed and random stimulus against a byte-queue reference model;
// a second instance with LSB-first order shares all inputs.
module tb_adler32_byte_feeder;
    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [1:0]  in_nbytes = '0;
    logic        in_ready, data_valid, last_data, busy;
    logic [7:0]  data;
    logic [15:0] byte_count;
    logic        in_ready_b, data_valid_b, last_data_b, busy_b;
    logic [7:0]  data_b;
    logic [15:0] byte_count_b;

    adler32_byte_feeder #(.DEPTH(4), .BYTE_ORDER(0), .GAP_CYCLES(2)) dut (
        .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_nbytes(in_nbytes), .data_valid(data_valid), .data(data),
        .last_data(last_data), .byte_count(byte_count), .busy(busy));

    adler32_byte_feeder #(.DEPTH(4), .BYTE_ORDER(1), .GAP_CYCLES(2)) dut_b (
        .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .in_last(in_last), .in_nbytes(in_nbytes), .data_valid(data_valid_b), .data(data_b),
        .last_data(last_data_b), .byte_count(byte_count_b), .busy(busy_b));

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic        last;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0, acc_cyc = 0, m_cnt = 0;
    int          zero_run = 0, last_gap = -1, bubbles = 0, first_dv_cyc = -1;
    bit          prev_dv = 0, prev_last = 1, ready_low_seen = 0;
    int unsigned sa = 1, sb = 0;
    logic [31:0] last_sum = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a word expands into its byte budget, each tagged with order-specific value and running count
    task automatic model_word(input logic [31:0] w, input bit last, input logic [1:0] nb);
        int n;
        exp_t e;
        n = last ? (nb == 2'd0 ? 4 : int'(nb)) : 4;
        for (int i = 0; i < n; i++) begin
            m_cnt  = (m_cnt == 65535) ? 65535 : m_cnt + 1;
            e.d0   = 8'(w >> (24 - 8 * i));
            e.d1   = 8'(w >> (8 * i));
            e.last = last && (i == n - 1);
            e.cnt  = 16'(m_cnt);
            q.push_back(e);
        end
        if (last) m_cnt = 0;
    endtask

    task automatic send(input logic [31:0] w, input bit last, input logic [1:0] nb);
        in_valid  = 1'b1;
        in_data   = w;
        in_last   = last;
        in_nbytes = nb;
        for (int k = 0; k < 200 && !in_ready; k++) @(negedge clock);
        if (!in_ready) begin
            chk("send_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        model_word(w, last, nb);
        acc_cyc = cyc + 1;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && (q.size() != 0 || busy); k++) @(negedge clock);
        chk("drain_queue", q.size(), 0);
        chk("drain_busy", busy, 0);
        repeat (3) @(negedge clock);
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        cyc++;
        if (!rst_n) begin
            zero_run  = 0;
            prev_dv   = 0;
            prev_last = 1;
        end else begin
            chk("order_b_valid", data_valid_b, data_valid);
            if (!in_ready) ready_low_seen = 1;
            if (data_valid) begin
                if (!prev_dv) first_dv_cyc = cyc;
                if (prev_last) begin
                    last_gap = zero_run;
                    sa = 1;
                    sb = 0;
                end
                if (q.size() == 0) begin
                    chk("unexpected_byte", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("data", data, e.d0);
                    chk("data_lsb_first", data_b, e.d1);
                    chk("last_data", last_data, e.last);
                    chk("last_data_b", last_data_b, e.last);
                    chk("byte_count", byte_count, e.cnt);
                    chk("byte_count_b", byte_count_b, e.cnt);
                end
                sa = (sa + data) % 65521;
                sb = (sb + sa) % 65521;
                if (last_data) last_sum = {sb[15:0], sa[15:0]};
                zero_run  = 0;
                prev_last = last_data;
            end else begin
                if (prev_dv && !prev_last && q.size() > 0) bubbles++;
                zero_run++;
                chk("last_without_valid", last_data, 0);
            end
            prev_dv = data_valid;
        end
    end

    initial begin
        int acc0, nw;
        bit found;
        repeat (3) @(negedge clock);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_data", data, 0);
        chk("rst_last_data", last_data, 0);
        chk("rst_byte_count", byte_count, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clock);
        chk("ready_after_release", in_ready, 1);

        // "Wikipedia" message and empty-to-first-byte latency
        first_dv_cyc = -1;
        send(32'h57696B69, 0, 2'd0);
        acc0 = acc_cyc;
        send(32'h70656469, 0, 2'd0);
        send(32'h61000000, 1, 2'd1);
        drain();
        chk("latency", first_dv_cyc - acc0, 2);
        chk("wiki_checksum", last_sum, 32'h11E60398);
        chk("wiki_byte_count", byte_count, 9);

        // Single full last word
        send(32'h41424344, 1, 2'd0);
        drain();
        chk("single_byte_count", byte_count, 4);

        // Two messages queued back to back
        last_gap = -1;
        send(32'h11223344, 0, 2'd0);
        send(32'h55667788, 1, 2'd2);
        send(32'h99AABBCC, 1, 2'd3);
        drain();
        chk("msg_gap", last_gap, 2);
        chk("b2b_byte_count", byte_count, 3);

        // Fill stress: continuous valid
        bubbles = 0;
        ready_low_seen = 0;
        for (int i = 0; i < 10; i++) send($urandom, 0, 2'd0);
        send($urandom, 1, 2'd1);
        drain();
        chk("fill_bubbles", bubbles, 0);
        chk("fill_ready_low", ready_low_seen, 1);
        chk("fill_byte_count", byte_count, 41);

        // Reset during the 3rd byte of a 12-byte message
        send(32'h01020304, 0, 2'd0);
        send(32'h05060708, 0, 2'd0);
        send(32'h090A0B0C, 1, 2'd0);
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (data_valid && byte_count == 16'd3) found = 1;
            else @(negedge clock);
        end
        chk("reach_third_byte", found, 1);
        rst_n = 1'b0;
        q.delete();
        m_cnt = 0;
        @(negedge clock);
        chk("midrst_data_valid", data_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_last_data", last_data, 0);
        rst_n = 1'b1;
        @(negedge clock);
        send(32'hDEADBEEF, 1, 2'd0);
        drain();
        chk("post_rst_byte_count", byte_count, 4);

        // Random messages with random upstream stalls
        for (int m = 0; m < 30; m++) begin
            nw = $urandom_range(1, 3);
            for (int j = 0; j < nw; j++) begin
                repeat ($urandom_range(0, 3)) @(negedge clock);
                send($urandom, j == nw - 1, 2'($urandom_range(0, 3)));
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
